alu_reservation_station: RTL and testbench
==========================================

// Module: alu_reservation_station
// PURPOSE
//  Integer-ALU reservation station directly downstream of decode. Accepts the 114-bit
//  dc2rs packet when decode selects the ALU (rs_dest[3]). Holds each instruction until
//  both operands are valid, snooping the CDB for tag matches to capture results.
//  Issues the oldest ready entry to the ALU over a valid/ready handshake.
//  Storage is a collapsing queue: index 0 is always the oldest entry.
// PARAMETERS
//  DEPTH   4   number of entries (2..16)
//  TAG_W   6   ROB tag width; equals width of dest_rob in dc2rs
// PORTS
//  clk          in   1    clock, rising edge
//  rst          in   1    asynchronous reset, active-high
//  flush        in   1    mispredict flush; invalidates all entries
//  dc_valid     in   1    decode presents an ALU op (rs_dest[3] & dispatch enable)
//  dc2rs        in   114  {inst[9:0], dest[5:0], opr1[32:0], opr2[32:0], offset[31:0]}
//  rs_full      out  1    no free entry; dispatch is not accepted
//  cdb_valid    in   1    common data bus broadcast this cycle
//  cdb_tag      in   6    ROB tag of broadcast result
//  cdb_data     in   32   broadcast result value
//  ex_valid     out  1    issue packet valid
//  ex_ready     in   1    ALU accepts packet
//  ex_inst      out  10   {funct7, funct3} of issued op
//  ex_dest      out  6    ROB tag of issued op
//  ex_opr1      out  32   operand 1 value
//  ex_opr2      out  32   operand 2 value
//  ex_offset    out  32   offset field, passed through
// BEHAVIOUR
//  Operand encoding: bit32 = 1 -> bits[31:0] hold the value; bit32 = 0 -> bits[TAG_W-1:0]
//   hold the producing ROB tag, and the remaining bits are ignored.
//  Reset (async): all entries invalid, count = 0, rs_full = 0, ex_valid = 0. ex_* payload
//   outputs are 0 whenever ex_valid = 0.
//  rs_full = (count == DEPTH), registered from count. Dispatch is accepted iff
//   dc_valid & !rs_full. Dispatch while full is dropped; no state change.
//  Accepted entry is written at index count (after collapse: count-1 if an issue fires
//   in the same cycle).
//  Wakeup: each cycle with cdb_valid, every valid entry operand with bit32 = 0 and
//   tag == cdb_tag becomes {1'b1, cdb_data}.
//  Dispatch bypass: an incoming operand whose tag matches the same-cycle CDB broadcast
//   is written already valid.
//  Ready entry: valid & opr1[32] & opr2[32].
//   ex_valid = any ready entry. The payload comes from the lowest-index ready entry
//   (the oldest), combinationally from stored state.
//  Latency: an entry written or woken at edge N is issuable in the cycle after edge N.
//   Minimum dispatch-to-ex_valid is 1 cycle. A CDB value arriving in the issue cycle is
//   not forwarded to ex_*.
//  Issue: on ex_valid & ex_ready, the selected entry is removed at the next edge.
//   Entries above it shift down by one, preserving order (their wakeups apply in the
//   same edge). If ex_ready = 0, the payload holds stable until taken or flushed.
//  Simultaneous dispatch + issue + wakeup are all handled in one edge.
//   count_next = count + accept - issue.
//  Full and issuing in the same cycle: rs_full is still 1, so dispatch is dropped.
//  flush: at the next edge all entries are invalid and count = 0. Flush dominates
//   dispatch, wakeup and issue in that cycle. An ex_valid&ex_ready handshake in the
//   flush cycle still counts as delivered; the ALU discards it on flush.
//  rst asserted mid-operation clears state immediately, regardless of clk.
//  Tag 0 carries no special meaning; upstream marks x0 operands as bit32 = 1.
// TESTING
//  1 Reset: assert rst mid-cycle with 3 valid entries -> ex_valid=0, rs_full=0 at once,
//    no issue after release.
//  2 Both ready: dispatch ADD opr1={1,5}, opr2={1,7}, dest=3 at edge 0, ex_ready=1
//    -> cycle 1 ex_valid=1, ex_dest=3, ex_opr1=5, ex_opr2=7. Queue empty after edge 1.
//  3 Wakeup: dispatch opr1={0,tag 9}, opr2={1,2}. CDB tag 9 data 0x10 two cycles later
//    -> ex_valid rises the cycle after the broadcast with ex_opr1=0x10.
//    Repeat with the broadcast in the dispatch cycle -> issue 1 cycle after dispatch.
//  4 Ordering: dispatch A(waits on tag 4), then B(ready), then C(ready) -> B then C
//    issue. After CDB tag 4, A issues. Entry order remains A before later arrivals.
//  5 Full/backpressure: DEPTH=4, ex_ready=0, fill 4 -> rs_full=1. A 5th dispatch is
//    dropped and the payload holds stable. ex_ready=1 for one cycle with dc_valid
//    -> dispatch dropped that cycle, accepted next.
//  6 Flush: 3 entries, flush with dc_valid=1 and cdb_valid=1
//    -> count=0, ex_valid=0 next cycle, new entry absent.

Source files
------------

// File: rtl/alu_reservation_station.sv
// Integer-ALU reservation station built as a collapsing queue with entry 0 the oldest.
// Operands wake on a CDB tag match, and the oldest ready entry issues over a valid/ready handshake.
module alu_reservation_station #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               dc_valid,
  input  logic [TAG_W+107:0] dc2rs,
  output logic               rs_full,
  input  logic               cdb_valid,
  input  logic [TAG_W-1:0]   cdb_tag,
  input  logic [31:0]        cdb_data,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [9:0]         ex_inst,
  output logic [TAG_W-1:0]   ex_dest,
  output logic [31:0]        ex_opr1,
  output logic [31:0]        ex_opr2,
  output logic [31:0]        ex_offset
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [9:0]       inst_q   [DEPTH];
  logic [9:0]       inst_d   [DEPTH];
  logic [TAG_W-1:0] dest_q   [DEPTH];
  logic [TAG_W-1:0] dest_d   [DEPTH];
  logic [32:0]      opr1_q   [DEPTH];
  logic [32:0]      opr1_d   [DEPTH];
  logic [32:0]      opr2_q   [DEPTH];
  logic [32:0]      opr2_d   [DEPTH];
  logic [31:0]      offset_q [DEPTH];
  logic [31:0]      offset_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;

  logic             sel_found;
  int               sel_idx;
  int               src_idx;
  int               wr_idx;
  logic             issue;
  logic             accept;

  logic [9:0]       in_inst;
  logic [TAG_W-1:0] in_dest;
  logic [32:0]      in_opr1;
  logic [32:0]      in_opr2;
  logic [31:0]      in_offset;

  assign in_offset = dc2rs[31:0];
  assign in_opr2   = dc2rs[64:32];
  assign in_opr1   = dc2rs[97:65];
  assign in_dest   = dc2rs[TAG_W+97:98];
  assign in_inst   = dc2rs[TAG_W+107:TAG_W+98];

  // A pending operand whose tag matches this cycle's broadcast becomes a valid value.
  function automatic logic [32:0] wake(input logic [32:0] opr);
    if (cdb_valid && !opr[32] && opr[TAG_W-1:0] == cdb_tag) begin
      return {1'b1, cdb_data};
    end
    return opr;
  endfunction

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!sel_found && i < int'(count_q) && opr1_q[i][32] && opr2_q[i][32]) begin
        sel_found = 1'b1;
        sel_idx   = i;
      end
    end

    ex_valid  = sel_found;
    ex_inst   = sel_found ? inst_q[sel_idx]         : '0;
    ex_dest   = sel_found ? dest_q[sel_idx]         : '0;
    ex_opr1   = sel_found ? opr1_q[sel_idx][31:0]   : '0;
    ex_opr2   = sel_found ? opr2_q[sel_idx][31:0]   : '0;
    ex_offset = sel_found ? offset_q[sel_idx]       : '0;

    issue  = sel_found & ex_ready;
    accept = dc_valid & ~full_q;
    wr_idx = int'(count_q) - int'(issue);

    src_idx = 0;
    for (int i = 0; i < DEPTH; i++) begin
      inst_d[i]   = inst_q[i];
      dest_d[i]   = dest_q[i];
      opr1_d[i]   = opr1_q[i];
      opr2_d[i]   = opr2_q[i];
      offset_d[i] = offset_q[i];
      // Entries at or above the issuing slot slide down one place.
      src_idx = (issue && i >= sel_idx) ? i + 1 : i;
      if (src_idx < DEPTH) begin
        inst_d[i]   = inst_q[src_idx];
        dest_d[i]   = dest_q[src_idx];
        opr1_d[i]   = wake(opr1_q[src_idx]);
        opr2_d[i]   = wake(opr2_q[src_idx]);
        offset_d[i] = offset_q[src_idx];
      end
      if (accept && i == wr_idx) begin
        inst_d[i]   = in_inst;
        dest_d[i]   = in_dest;
        opr1_d[i]   = wake(in_opr1);
        opr2_d[i]   = wake(in_opr2);
        offset_d[i] = in_offset;
      end
    end

    count_d = CW'(int'(count_q) + int'(accept) - int'(issue));
    if (flush) begin
      count_d = '0;
    end
    full_d = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i]   <= '0;
        dest_q[i]   <= '0;
        opr1_q[i]   <= '0;
        opr2_q[i]   <= '0;
        offset_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i]   <= inst_d[i];
        dest_q[i]   <= dest_d[i];
        opr1_q[i]   <= opr1_d[i];
        opr2_q[i]   <= opr2_d[i];
        offset_q[i] <= offset_d[i];
      end
    end
  end

  assign rs_full = full_q;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: a directed vector table plus hand sequences
// covering backpressure, full, flush and asynchronous reset.
module tb_alu_reservation_station;
  logic         clk;
  logic         rst;
  logic         flush;
  logic         dc_valid;
  logic [113:0] dc2rs;
  logic         rs_full;
  logic         cdb_valid;
  logic [5:0]   cdb_tag;
  logic [31:0]  cdb_data;
  logic         ex_valid;
  logic         ex_ready;
  logic [9:0]   ex_inst;
  logic [5:0]   ex_dest;
  logic [31:0]  ex_opr1;
  logic [31:0]  ex_opr2;
  logic [31:0]  ex_offset;

  int n_cmp = 0;
  int n_err = 0;

  alu_reservation_station #(.DEPTH(4), .TAG_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush), .dc_valid(dc_valid), .dc2rs(dc2rs),
    .rs_full(rs_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_inst(ex_inst), .ex_dest(ex_dest),
    .ex_opr1(ex_opr1), .ex_opr2(ex_opr2), .ex_offset(ex_offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [9:0]  inst;
    logic [5:0]  dest;
    logic [32:0] o1;
    logic [32:0] o2;
    logic [31:0] off;
    logic        cv;
    logic [5:0]  ctag;
    logic [31:0] cdata;
    logic        rdy;
    logic        e_v;
    logic [9:0]  e_inst;
    logic [5:0]  e_dest;
    logic [31:0] e_o1;
    logic [31:0] e_o2;
    logic [31:0] e_off;
    logic        e_full;
  } vec_t;

  vec_t vecs[21];

  function automatic logic [32:0] ov(input int x);
    return {1'b1, 32'(x)};
  endfunction

  function automatic logic [32:0] ot(input int x);
    return {1'b0, 32'(x)};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [9:0] inst, input logic [5:0] dest, input logic [32:0] o1,
                      input logic [32:0] o2, input logic [31:0] off);
    dc_valid = 1'b1;
    dc2rs    = {inst, dest, o1, o2, off};
  endtask

  task automatic idle();
    dc_valid  = 1'b0;
    dc2rs     = '0;
    cdb_valid = 1'b0;
    cdb_tag   = '0;
    cdb_data  = '0;
    flush     = 1'b0;
  endtask

  task automatic chk_head(input string name, input logic v, input logic [5:0] dest, input logic full);
    chk({name, ".ex_valid"}, 64'(ex_valid), 64'(v));
    chk({name, ".ex_dest"}, 64'(ex_dest), 64'(dest));
    chk({name, ".rs_full"}, 64'(rs_full), 64'(full));
    $display("%s: ex_valid=%b ex_dest=%0d rs_full=%b", name, ex_valid, ex_dest, rs_full);
  endtask

  initial begin
    // Both ready: ADD dispatched, issued the next cycle, queue empty afterwards.
    vecs[0]  = '{1'b1, 10'h000, 6'd3,  ov(5),  ov(7), 32'h100, 1'b0, 6'd0,  32'h0,  1'b1, 1'b0, 10'h000, 6'd0,  32'h0,    32'h0,    32'h0,   1'b0};
    vecs[1]  = '{1'b0, 10'h000, 6'd0,  33'd0,  33'd0, 32'h0,   1'b0, 6'd0,  32'h0,  1'b1, 1'b1, 10'h000, 6'd3,  32'd5,    32'd7,    32'h100, 1'b0};
    vecs[2]  = '{1'b0, 10'h000, 6'd0,  33'd0,  33'd0, 32'h0,   1'b0, 6'd0,  32'h0,  1'b1, 1'b0, 10'h000, 6'd0,  32'h0,    32'h0,    32'h0,   1'b0};
    // Wakeup two cycles after dispatch; upper bits of the tag operand are ignored.
    vecs[3]  = '{1'b1, 10'h007, 6'd10, ot(32'hDEADBE09), ov(2), 32'h200, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 10'h000, 6'd0, 32'h0, 32'h0, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 10'h000, 6'd0,  33'd0,  33'd0, 32'h0,   1'b0, 6'd0,  32'h0,  1'b1, 1'b0, 10'h000, 6'd0,  32'h0,    32'h0,    32'h0,   1'b0};
    vecs[5]  = '{1'b0, 10'h000, 6'd0,  33'd0,  33'd0, 32'h0,   1'b1, 6'd9,  32'h10, 1'b1, 1'b0, 10'h000, 6'd0,  32'h0,    32'h0,    32'h0,   1'b0};
    vecs[6]  = '{1'b0, 10'h000, 6'd0,  33'd0,  33'd0, 32'h0,   1'b0, 6'd0,  32'h0,  1'b1, 1'b1, 10'h007, 6'd10, 32'h10,   32'd2,    32'h200, 1'b0};
    // Broadcast in the dispatch cycle: bypassed into the entry.
    vecs[7]  = '{1'b1, 10'h004, 6'd11, ot(9),  ov(2), 32'h300, 1'b1, 6'd9,  32'h20, 1'b1, 1'b0, 10'h000, 6'd0,  32'h0,    32'h0,    32'h0,   1'b0};
    vecs[8]  = '{1'b0, 10'h000, 6'd0,  33'd0,  33'd0, 32'h0,   1'b0, 6'd0,  32'h0,  1'b1, 1'b1, 10'h004, 6'd11, 32'h20,   32'd2,    32'h300, 1'b0};
    // Ordering: A waits on tag 4, B and C issue first, A then precedes later D.
    vecs[9]  = '{1'b1, 10'h100, 6'd1,  ot(32'hABCD0004), ov(1), 32'h11, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 10'h000, 6'd0, 32'h0, 32'h0, 32'h0, 1'b0};
    vecs[10] = '{1'b1, 10'h001, 6'd2,  ov(32'h22), ov(32'h33), 32'h12, 1'b0, 6'd0, 32'h0, 1'b1, 1'b0, 10'h000, 6'd0, 32'h0, 32'h0, 32'h0, 1'b0};
    vecs[11] = '{1'b1, 10'h002, 6'd5,  ov(32'h44), ov(32'h55), 32'h13, 1'b0, 6'd0, 32'h0, 1'b1, 1'b1, 10'h001, 6'd2, 32'h22, 32'h33, 32'h12, 1'b0};
    vecs[12] = '{1'b0, 10'h000, 6'd0,  33'd0,  33'd0, 32'h0,   1'b0, 6'd0,  32'h0,  1'b1, 1'b1, 10'h002, 6'd5,  32'h44,   32'h55,   32'h13,  1'b0};
    vecs[13] = '{1'b1, 10'h006, 6'd7,  ov(32'h77), ov(32'h78), 32'h14, 1'b1, 6'd4, 32'h99, 1'b1, 1'b0, 10'h000, 6'd0, 32'h0, 32'h0, 32'h0, 1'b0};
    vecs[14] = '{1'b0, 10'h000, 6'd0,  33'd0,  33'd0, 32'h0,   1'b0, 6'd0,  32'h0,  1'b1, 1'b1, 10'h100, 6'd1,  32'h99,   32'd1,    32'h11,  1'b0};
    vecs[15] = '{1'b0, 10'h000, 6'd0,  33'd0,  33'd0, 32'h0,   1'b0, 6'd0,  32'h0,  1'b1, 1'b1, 10'h006, 6'd7,  32'h77,   32'h78,   32'h14,  1'b0};
    // Wakeup applied to an entry that shifts down in the same edge.
    vecs[16] = '{1'b1, 10'h003, 6'd8,  ov(1),  ov(1), 32'h15,  1'b0, 6'd0,  32'h0,  1'b1, 1'b0, 10'h000, 6'd0,  32'h0,    32'h0,    32'h0,   1'b0};
    vecs[17] = '{1'b1, 10'h005, 6'd9,  ot(13), ov(3), 32'h16,  1'b0, 6'd0,  32'h0,  1'b0, 1'b1, 10'h003, 6'd8,  32'd1,    32'd1,    32'h15,  1'b0};
    vecs[18] = '{1'b0, 10'h000, 6'd0,  33'd0,  33'd0, 32'h0,   1'b1, 6'd13, 32'h5A, 1'b1, 1'b1, 10'h003, 6'd8,  32'd1,    32'd1,    32'h15,  1'b0};
    vecs[19] = '{1'b0, 10'h000, 6'd0,  33'd0,  33'd0, 32'h0,   1'b0, 6'd0,  32'h0,  1'b1, 1'b1, 10'h005, 6'd9,  32'h5A,   32'd3,    32'h16,  1'b0};
    vecs[20] = '{1'b0, 10'h000, 6'd0,  33'd0,  33'd0, 32'h0,   1'b0, 6'd0,  32'h0,  1'b1, 1'b0, 10'h000, 6'd0,  32'h0,    32'h0,    32'h0,   1'b0};

    rst = 1'b1;
    ex_ready = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk_head("reset", 1'b0, 6'd0, 1'b0);
    chk("reset.ex_opr1", 64'(ex_opr1), 64'd0);

    for (int k = 0; k < 21; k++) begin
      dc_valid  = vecs[k].dv;
      dc2rs     = {vecs[k].inst, vecs[k].dest, vecs[k].o1, vecs[k].o2, vecs[k].off};
      cdb_valid = vecs[k].cv;
      cdb_tag   = vecs[k].ctag;
      cdb_data  = vecs[k].cdata;
      ex_ready  = vecs[k].rdy;
      #1;
      chk($sformatf("v%0d.ex_valid", k),  64'(ex_valid),  64'(vecs[k].e_v));
      chk($sformatf("v%0d.ex_inst", k),   64'(ex_inst),   64'(vecs[k].e_inst));
      chk($sformatf("v%0d.ex_dest", k),   64'(ex_dest),   64'(vecs[k].e_dest));
      chk($sformatf("v%0d.ex_opr1", k),   64'(ex_opr1),   64'(vecs[k].e_o1));
      chk($sformatf("v%0d.ex_opr2", k),   64'(ex_opr2),   64'(vecs[k].e_o2));
      chk($sformatf("v%0d.ex_offset", k), 64'(ex_offset), 64'(vecs[k].e_off));
      chk($sformatf("v%0d.rs_full", k),   64'(rs_full),   64'(vecs[k].e_full));
      $display("vec %0d: ex_valid=%b dest=%0d opr1=%0h opr2=%0h full=%b",
               k, ex_valid, ex_dest, ex_opr1, ex_opr2, rs_full);
      tick();
    end
    idle();
    ex_ready = 1'b0;

    // Full and backpressure.
    for (int k = 0; k < 4; k++) begin
      disp(10'h000, 6'(20 + k), ov(32'h1000 + k), ov(k), 32'(k));
      tick();
    end
    idle();
    #1;
    chk_head("full.fill", 1'b1, 6'd20, 1'b1);
    chk("full.fill.ex_opr1", 64'(ex_opr1), 64'h1000);
    disp(10'h000, 6'd24, ov(1), ov(1), 32'h0);
    tick();
    idle();
    #1;
    chk_head("full.drop5", 1'b1, 6'd20, 1'b1);
    chk("full.drop5.ex_opr1", 64'(ex_opr1), 64'h1000);
    disp(10'h000, 6'd25, ov(32'h2500), ov(1), 32'h0);
    ex_ready = 1'b1;
    #1;
    chk_head("full.issue_cyc", 1'b1, 6'd20, 1'b1);
    tick();
    ex_ready = 1'b0;
    #1;
    chk_head("full.after_issue", 1'b1, 6'd21, 1'b0);
    tick();
    idle();
    #1;
    chk_head("full.accept_next", 1'b1, 6'd21, 1'b1);
    ex_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      automatic logic [5:0] want = (k == 3) ? 6'd25 : 6'(21 + k);
      chk_head($sformatf("full.drain%0d", k), 1'b1, want, 1'b0 == 1'b1 ? 1'b0 : (k == 0));
      tick();
    end
    #1;
    chk_head("full.empty", 1'b0, 6'd0, 1'b0);
    ex_ready = 1'b0;

    // Flush with dispatch and broadcast in the same cycle.
    for (int k = 0; k < 3; k++) begin
      disp(10'h001, 6'(40 + k), ot(12), ov(0), 32'h0);
      tick();
    end
    idle();
    flush = 1'b1;
    disp(10'h002, 6'd30, ov(3), ov(4), 32'h0);
    cdb_valid = 1'b1;
    cdb_tag   = 6'd12;
    cdb_data  = 32'h77;
    ex_ready  = 1'b1;
    tick();
    idle();
    ex_ready = 1'b0;
    #1;
    chk_head("flush.next", 1'b0, 6'd0, 1'b0);
    tick();
    chk_head("flush.absent", 1'b0, 6'd0, 1'b0);

    // Count restarts at zero after flush: exactly four dispatches fill it.
    for (int k = 0; k < 4; k++) begin
      disp(10'h000, 6'(50 + k), ov(k), ov(k), 32'h0);
      tick();
      if (k == 2) chk_head("flush.count3", 1'b1, 6'd50, 1'b0);
    end
    idle();
    chk_head("flush.count4", 1'b1, 6'd50, 1'b1);
    ex_ready = 1'b1;
    tick();
    ex_ready = 1'b0;
    chk_head("rst.pre", 1'b1, 6'd51, 1'b0);

    // Asynchronous reset mid-cycle with three valid entries.
    #2 rst = 1'b1;
    #1;
    chk_head("rst.async", 1'b0, 6'd0, 1'b0);
    #2 rst = 1'b0;
    ex_ready = 1'b1;
    tick();
    chk_head("rst.after1", 1'b0, 6'd0, 1'b0);
    tick();
    chk_head("rst.after2", 1'b0, 6'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
